// File: rtl/door_lock_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// door_lock_ctrl_pkg
// Shared constants for the stage exit door: game FSM stage codes, door
// geometry in half-resolution pixel space (also used by the door renderer),
// the door controller state type and a stage-code classifier.
// ---------------------------------------------------------------------------
package door_lock_ctrl_pkg;

  // Game FSM state codes that correspond to playable stages
  localparam logic [3:0] STAGE1 = 4'd2;
  localparam logic [3:0] STAGE2 = 4'd4;
  localparam logic [3:0] STAGE3 = 4'd6;

  // Door rectangle, half-res coordinates; 10 bits so X0+W cannot wrap
  localparam logic [9:0] DOOR_X0 = 10'd260;
  localparam logic [9:0] DOOR_Y0 = 10'd127;
  localparam logic [9:0] DOOR_W  = 10'd10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOCKED    = 3'd1,
    S_UNLOCKING = 3'd2,
    S_OPEN      = 3'd3,
    S_EXITED    = 3'd4
  } door_state_e;

  // True when a game FSM code names one of the playable stages
  function automatic logic is_stage(input logic [3:0] code);
    return (code == STAGE1) || (code == STAGE2) || (code == STAGE3);
  endfunction

endpackage

// File: rtl/door_hit_box.sv
// ---------------------------------------------------------------------------
// door_hit_box
// Combinational test of whether the player position lies inside the door
// rectangle (left/top inclusive, right/bottom exclusive).
// Ports:
//   i_player_x  in  9  player x, half-res
//   i_player_y  in  9  player y, half-res
//   o_in_box    out 1  1 = player inside the door rectangle
// ---------------------------------------------------------------------------
module door_hit_box
  import door_lock_ctrl_pkg::*;
(
  input  logic [8:0] i_player_x,
  input  logic [8:0] i_player_y,
  output logic       o_in_box
);

  logic [9:0] w_x;
  logic [9:0] w_y;

  // Widen to 10 bits before comparing against X0+W / Y0+W
  assign w_x = {1'b0, i_player_x};
  assign w_y = {1'b0, i_player_y};

  assign o_in_box = (w_x >= DOOR_X0) && (w_x < (DOOR_X0 + DOOR_W)) &&
                    (w_y >= DOOR_Y0) && (w_y < (DOOR_Y0 + DOOR_W));

endmodule

// File: rtl/door_lock_ctrl.sv
// ---------------------------------------------------------------------------
// door_lock_ctrl
// Per-stage exit door sequencer. Counts keys collected in the current stage,
// unlocks once the stage quota is met, blinks the door sprite for a fixed
// time, then opens and reports a one-cycle stage_exit when the player enters.
// Ports:
//   clk          in  1  system clock
//   rst          in  1  synchronous active-high reset
//   state        in  4  game FSM state code
//   key_got      in  1  pulse: key collected
//   player_x/y   in  9  player position, half-res
//   enter_btn    in  1  pulse: enter-door request
//   isLocked     out 1  door renderer sprite select (1 = locked)
//   door_open    out 1  level: door fully open
//   stage_exit   out 1  pulse: player went through the door
//   locked_bump  out 1  pulse: enter attempted on a non-open door
//   keys_held    out 2  keys collected this stage, saturating at 3
// ---------------------------------------------------------------------------
module door_lock_ctrl
  import door_lock_ctrl_pkg::*;
#(
  parameter int unsigned KEYS_S1       = 1,
  parameter int unsigned KEYS_S2       = 2,
  parameter int unsigned KEYS_S3       = 3,
  parameter int unsigned UNLOCK_CYCLES = 50_000_000,
  parameter int unsigned BLINK_CYCLES  = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       key_got,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic       enter_btn,
  output logic       isLocked,
  output logic       door_open,
  output logic       stage_exit,
  output logic       locked_bump,
  output logic [1:0] keys_held
);

  localparam int UCW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
  localparam int BCW = (BLINK_CYCLES  > 1) ? $clog2(BLINK_CYCLES)  : 1;
  localparam logic [UCW-1:0] UCNT_ONE  = UCW'(1);
  localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);
  localparam logic [UCW-1:0] UCNT_LAST = UCW'(UNLOCK_CYCLES - 1);
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(BLINK_CYCLES - 1);

  door_state_e     r_state;
  door_state_e     w_next_state;
  logic [3:0]      r_prev_state;
  logic [1:0]      r_keys;
  logic [1:0]      w_keys_next;
  logic [1:0]      w_keys_inc;
  logic [1:0]      w_quota;
  logic [UCW-1:0]  r_ucnt;
  logic [UCW-1:0]  w_ucnt_next;
  logic [BCW-1:0]  r_bcnt;
  logic [BCW-1:0]  w_bcnt_next;
  logic            r_islocked;
  logic            w_islocked_next;
  logic            r_open;
  logic            w_open_next;
  logic            r_exit;
  logic            w_exit_next;
  logic            r_bump;
  logic            w_bump_next;
  logic            w_in_box;
  logic            w_enter_hit;

  door_hit_box u_hit_box (
    .i_player_x (player_x),
    .i_player_y (player_y),
    .o_in_box   (w_in_box)
  );

  assign w_enter_hit = enter_btn & w_in_box;
  assign w_keys_inc  = (r_keys == 2'd3) ? 2'd3 : (r_keys + 2'd1);

  // Key quota of the stage currently being played
  always_comb begin
    case (state)
      STAGE1:  w_quota = 2'(KEYS_S1);
      STAGE2:  w_quota = 2'(KEYS_S2);
      STAGE3:  w_quota = 2'(KEYS_S3);
      default: w_quota = 2'd0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_next_state    = r_state;
    w_keys_next     = r_keys;
    w_ucnt_next     = r_ucnt;
    w_bcnt_next     = r_bcnt;
    w_islocked_next = r_islocked;
    w_open_next     = r_open;
    w_exit_next     = 1'b0;
    w_bump_next     = 1'b0;

    // A stage change overrides everything else; same-cycle key/enter are dropped
    if (state != r_prev_state) begin
      w_next_state    = is_stage(state) ? S_LOCKED : S_IDLE;
      w_keys_next     = 2'd0;
      w_ucnt_next     = '0;
      w_bcnt_next     = '0;
      w_islocked_next = 1'b1;
      w_open_next     = 1'b0;
    end else if (!is_stage(state)) begin
      w_next_state    = S_IDLE;
      w_islocked_next = 1'b1;
      w_open_next     = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_islocked_next = 1'b1;
          w_open_next     = 1'b0;
        end
        S_LOCKED: begin
          if (key_got) begin
            w_keys_next = w_keys_inc;
          end else begin
            w_keys_next = r_keys;
          end
          w_bump_next = w_enter_hit;
          // Quota checked on the post-increment count; a zero quota unlocks at once
          if (w_keys_next >= w_quota) begin
            w_next_state    = S_UNLOCKING;
            w_ucnt_next     = '0;
            w_bcnt_next     = '0;
            w_islocked_next = 1'b1;
          end else begin
            w_next_state    = S_LOCKED;
          end
        end
        S_UNLOCKING: begin
          if (key_got) begin
            w_keys_next = w_keys_inc;
          end else begin
            w_keys_next = r_keys;
          end
          w_bump_next = w_enter_hit;
          if (r_ucnt == UCNT_LAST) begin
            w_next_state    = S_OPEN;
            w_ucnt_next     = '0;
            w_bcnt_next     = '0;
            w_islocked_next = 1'b0;
            w_open_next     = 1'b1;
          end else begin
            w_ucnt_next = r_ucnt + UCNT_ONE;
            // Blink: flip the sprite every BLINK_CYCLES cycles of the unlock phase
            if (r_bcnt == BCNT_LAST) begin
              w_bcnt_next     = '0;
              w_islocked_next = ~r_islocked;
            end else begin
              w_bcnt_next     = r_bcnt + BCNT_ONE;
            end
          end
        end
        S_OPEN: begin
          if (w_enter_hit) begin
            w_next_state = S_EXITED;
            w_exit_next  = 1'b1;
          end else begin
            w_next_state = S_OPEN;
          end
        end
        S_EXITED: begin
          w_islocked_next = 1'b0;
          w_open_next     = 1'b1;
        end
        default: begin
          w_next_state    = S_IDLE;
          w_islocked_next = 1'b1;
          w_open_next     = 1'b0;
        end
      endcase
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_prev_state <= 4'd0;
      r_keys       <= 2'd0;
      r_ucnt       <= '0;
      r_bcnt       <= '0;
      r_islocked   <= 1'b1;
      r_open       <= 1'b0;
      r_exit       <= 1'b0;
      r_bump       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_prev_state <= state;
      r_keys       <= w_keys_next;
      r_ucnt       <= w_ucnt_next;
      r_bcnt       <= w_bcnt_next;
      r_islocked   <= w_islocked_next;
      r_open       <= w_open_next;
      r_exit       <= w_exit_next;
      r_bump       <= w_bump_next;
    end
  end

  assign isLocked    = r_islocked;
  assign door_open   = r_open;
  assign stage_exit  = r_exit;
  assign locked_bump = r_bump;
  assign keys_held   = r_keys;

endmodule
